// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand/operator sequencing and
// start/done handshake with the arithmetic unit; all outputs registered.
module calc_sequencer #(
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       alu_done,
    input  logic       alu_ovf,
    output logic       digit_push,
    output logic [3:0] digit,
    output logic       entry_clear,
    output logic       sign_toggle,
    output logic       latch_a,
    output logic       latch_b,
    output logic       latch_result_a,
    output logic [1:0] op,
    output logic       alu_start,
    output logic       result_valid,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      state_q;
    logic        key_prev_q;
    logic [2:0]  count_q;
    logic [15:0] tmo_q;
    logic [1:0]  op_q;
    logic [3:0]  digit_q;
    logic        push_q, clr_q, sgn_q, la_q, lb_q, lr_q;
    logic        start_q, rv_q, err_q;

    logic        key_ev, is_digit, is_op, is_eq, is_clr, is_sgn;
    logic        room;
    logic [1:0]  op_code;

    // Decode the rising edge of the key level into one key event.
    always_comb begin
        key_ev   = key_valid & ~key_prev_q;
        is_digit = key_ev && (key_value <= 4'd9);
        is_op    = key_ev && (key_value >= 4'hA) && (key_value <= 4'hC);
        is_clr   = key_ev && (key_value == 4'hD);
        is_eq    = key_ev && (key_value == 4'hE);
        is_sgn   = key_ev && (key_value == 4'hF);
        room     = (count_q < 3'(MAX_DIGITS));
        op_code  = key_value[1:0] + 2'b10;
    end

    // Sequencer FSM; pulses default low and fire for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_A;
            key_prev_q <= 1'b1;
            count_q    <= '0;
            tmo_q      <= '0;
            op_q       <= 2'b00;
            digit_q    <= '0;
            push_q     <= 1'b0;
            clr_q      <= 1'b0;
            sgn_q      <= 1'b0;
            la_q       <= 1'b0;
            lb_q       <= 1'b0;
            lr_q       <= 1'b0;
            start_q    <= 1'b0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            key_prev_q <= key_valid;
            push_q     <= 1'b0;
            clr_q      <= 1'b0;
            sgn_q      <= 1'b0;
            la_q       <= 1'b0;
            lb_q       <= 1'b0;
            lr_q       <= 1'b0;
            start_q    <= 1'b0;
            if (is_clr) begin
                clr_q   <= 1'b1;
                count_q <= '0;
                op_q    <= 2'b00;
                rv_q    <= 1'b0;
                err_q   <= 1'b0;
                state_q <= S_A;
            end else begin
                case (state_q)
                    S_A, S_B: begin
                        if (is_digit && room) begin
                            push_q  <= 1'b1;
                            digit_q <= key_value;
                            count_q <= count_q + 3'd1;
                        end else if (is_sgn) begin
                            sgn_q <= 1'b1;
                        end else if (is_op && state_q == S_A) begin
                            la_q    <= 1'b1;
                            clr_q   <= 1'b1;
                            op_q    <= op_code;
                            count_q <= '0;
                            state_q <= S_B;
                        end else if (is_op && count_q == '0) begin
                            op_q <= op_code;
                        end else if (is_eq && state_q == S_B) begin
                            if (count_q == '0) begin
                                err_q   <= 1'b1;
                                state_q <= S_ERR;
                            end else begin
                                lb_q    <= 1'b1;
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        start_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        // done coinciding with our own start pulse is too early
                        if (alu_done && !start_q) begin
                            if (alu_ovf) begin
                                err_q   <= 1'b1;
                                state_q <= S_ERR;
                            end else begin
                                rv_q    <= 1'b1;
                                state_q <= S_RES;
                            end
                        end else if (tmo_q == 16'(TIMEOUT)) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            tmo_q <= tmo_q + 16'd1;
                        end
                    end
                    S_RES: begin
                        if (is_op) begin
                            lr_q    <= 1'b1;
                            clr_q   <= 1'b1;
                            op_q    <= op_code;
                            count_q <= '0;
                            rv_q    <= 1'b0;
                            state_q <= S_B;
                        end
                    end
                    S_ERR: ;
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign digit_push     = push_q;
    assign digit          = digit_q;
    assign entry_clear    = clr_q;
    assign sign_toggle    = sgn_q;
    assign latch_a        = la_q;
    assign latch_b        = lb_q;
    assign latch_result_a = lr_q;
    assign op             = op_q;
    assign alu_start      = start_q;
    assign result_valid   = rv_q;
    assign error          = err_q;
    assign state          = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scenarios plus random key/ALU traffic,
// checked every cycle against a key-event level model of the sequencer.
module tb_calc_sequencer;

    localparam int MAXD = 3;
    localparam int TMO  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       alu_done = 1'b0;
    logic       alu_ovf = 1'b0;
    logic       digit_push, entry_clear, sign_toggle;
    logic       latch_a, latch_b, latch_result_a;
    logic       alu_start, result_valid, error;
    logic [3:0] digit;
    logic [1:0] op;
    logic [2:0] state;

    always #5 clk = ~clk;

    calc_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_value(key_value),
        .alu_done(alu_done), .alu_ovf(alu_ovf),
        .digit_push(digit_push), .digit(digit),
        .entry_clear(entry_clear), .sign_toggle(sign_toggle),
        .latch_a(latch_a), .latch_b(latch_b),
        .latch_result_a(latch_result_a), .op(op),
        .alu_start(alu_start), .result_valid(result_valid),
        .error(error), .state(state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         started = 0;
    int         m_st = 0, m_cnt = 0, m_el = 0;
    logic [1:0] m_op = 0;
    bit         m_prev = 1;
    bit         e_push, e_clr, e_sgn, e_la, e_lb, e_lr, e_start;
    bit         e_rv, e_err;
    logic [3:0] e_dig;

    task automatic model_step();
        bit ev, isdig, isop;
        logic [3:0] k;
        started = 1;
        {e_push, e_clr, e_sgn, e_la, e_lb, e_lr, e_start} = '0;
        e_dig = 0;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_op = 0; m_prev = 1; m_el = 0;
            e_rv = 0; e_err = 0;
            return;
        end
        ev = key_valid && !m_prev;
        m_prev = key_valid;
        k = key_value;
        isdig = ev && k <= 9;
        isop = ev && k >= 10 && k <= 12;
        if (ev && k == 13) begin
            e_clr = 1; m_cnt = 0; m_op = 0;
            e_rv = 0; e_err = 0; m_st = 0;
            return;
        end
        case (m_st)
            0, 1: begin
                if (isdig && m_cnt < MAXD) begin
                    e_push = 1; e_dig = k; m_cnt++;
                end else if (ev && k == 15) begin
                    e_sgn = 1;
                end else if (isop && m_st == 0) begin
                    e_la = 1; e_clr = 1; m_op = 2'(k - 10);
                    m_cnt = 0; m_st = 1;
                end else if (isop && m_cnt == 0) begin
                    m_op = 2'(k - 10);
                end else if (ev && k == 14 && m_st == 1) begin
                    if (m_cnt == 0) begin
                        m_st = 5; e_err = 1;
                    end else begin
                        e_lb = 1; m_st = 2;
                    end
                end
            end
            2: begin
                e_start = 1; m_el = 0; m_st = 3;
            end
            3: begin
                m_el++;
                if (alu_done && m_el >= 2) begin
                    if (alu_ovf) begin
                        m_st = 5; e_err = 1;
                    end else begin
                        m_st = 4; e_rv = 1;
                    end
                end else if (m_el == TMO + 1) begin
                    m_st = 5; e_err = 1;
                end
            end
            4: if (isop) begin
                e_lr = 1; e_clr = 1; m_op = 2'(k - 10);
                m_cnt = 0; m_st = 1; e_rv = 0;
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [17:0] act, exp;
        @(negedge clk);
        if (started) begin
            act = {digit_push, digit_push ? digit : 4'd0, entry_clear,
                   sign_toggle, latch_a, latch_b, latch_result_a, op,
                   alu_start, result_valid, error, state};
            exp = {e_push, e_dig, e_clr, e_sgn, e_la, e_lb, e_lr, m_op,
                   e_start, e_rv, e_err, 3'(m_st)};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cycle outputs @%0t: got %h expected %h",
                         $time, act, exp);
            end
        end
    end

    // ---------------- event monitor ----------------
    int n_push = 0, n_la = 0, n_lb = 0, n_st = 0, n_lrc = 0, n_clr = 0;
    int cyc = 0, start_cyc = 0, err_cyc = 0;
    bit err_prev = 0;
    logic [3:0] digq[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (digit_push === 1'b1) begin
            n_push++;
            digq.push_back(digit);
        end
        if (latch_a === 1'b1) n_la++;
        if (latch_b === 1'b1) n_lb++;
        if (entry_clear === 1'b1) n_clr++;
        if (latch_result_a === 1'b1 && entry_clear === 1'b1) n_lrc++;
        if (alu_start === 1'b1) begin
            n_st++;
            start_cyc = cyc;
        end
        if (error === 1'b1 && !err_prev) err_cyc = cyc;
        err_prev = (error === 1'b1);
    end

    // ---------------- ALU responder ----------------
    int alu_dly = 2;
    bit ovf_sel = 0, alu_rand = 0, stray_en = 0;
    int late_cnt = 0, late_done = 0;

    initial forever begin
        int d;
        logic o;
        @(negedge clk);
        if (alu_start === 1'b1) begin
            d = alu_rand ? int'($urandom_range(0, 11)) : alu_dly;
            o = alu_rand ? ($urandom_range(0, 3) == 0) : ovf_sel;
            if (d >= 0) begin
                repeat (d) @(negedge clk);
                alu_done = 1; alu_ovf = o;
                @(negedge clk);
                alu_done = 0; alu_ovf = 0;
            end
        end else if (late_cnt != late_done) begin
            late_done++;
            alu_done = 1;
            @(negedge clk);
            alu_done = 0;
        end else if (stray_en && $urandom_range(0, 19) == 0) begin
            alu_done = 1; alu_ovf = 1'($urandom_range(0, 1));
            @(negedge clk);
            alu_done = 0; alu_ovf = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] k, input int hold = 1);
        key_valid = 1; key_value = k;
        repeat (hold) @(negedge clk);
        key_valid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int i = 0;
        while (state !== 3'(s) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(nm, 32'(state), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, b2, b3, bq, r;
        repeat (3) @(negedge clk);
        check("reset state", 32'(state), 0);
        check("reset error", 32'(error), 0);
        check("reset result_valid", 32'(result_valid), 0);
        check("reset op", 32'(op), 0);
        reset = 0;
        @(negedge clk);

        // 1,2,A,3,E with done two cycles after start
        b0 = n_push; b1 = n_la; b2 = n_lb; b3 = n_st; bq = digq.size();
        press(1); press(2); press(4'hA); press(3); press(4'hE);
        wait_state(4, 30, "t1 reach S_RES");
        check("t1 pushes", 32'(n_push - b0), 3);
        check("t1 digit0", 32'(digq[bq]), 1);
        check("t1 digit1", 32'(digq[bq+1]), 2);
        check("t1 digit2", 32'(digq[bq+2]), 3);
        check("t1 latch_a", 32'(n_la - b1), 1);
        check("t1 latch_b", 32'(n_lb - b2), 1);
        check("t1 alu_start", 32'(n_st - b3), 1);
        check("t1 result_valid", 32'(result_valid), 1);
        check("t1 op", 32'(op), 0);

        // chaining from S_RES
        b0 = n_lrc; b3 = n_st;
        press(4'hA);
        check("t5 lr+clr", 32'(n_lrc - b0), 1);
        check("t5 state", 32'(state), 1);
        check("t5 op", 32'(op), 0);
        press(7); press(4'hE);
        wait_state(4, 30, "t5 second result");
        check("t5 second start", 32'(n_st - b3), 1);

        // digit limit and long hold
        press(4'hD);
        b0 = n_push;
        press(5, 10);
        check("t2 held key one event", 32'(n_push - b0), 1);
        press(5); press(5); press(5);
        check("t2 digit limit", 32'(n_push - b0), 3);

        // E with no B digits
        press(4'hD);
        b3 = n_st;
        press(9); press(4'hB); press(4'hE);
        check("t3 error", 32'(error), 1);
        check("t3 state", 32'(state), 5);
        check("t3 no start", 32'(n_st - b3), 0);
        b0 = n_clr;
        press(4'hD);
        check("t3 clear pulse", 32'(n_clr - b0), 1);
        check("t3 state after D", 32'(state), 0);
        check("t3 error after D", 32'(error), 0);

        // timeout
        alu_dly = -1;
        press(4); press(4'hC); press(2); press(4'hE);
        wait_state(5, 40, "t4 timeout error");
        check("t4 timeout latency", 32'(err_cyc - start_cyc), 32'(TMO + 1));
        late_cnt++;
        repeat (4) @(negedge clk);
        check("t4 late done ignored", 32'(state), 5);

        // reset while waiting, key held through it
        press(4'hD);
        press(1); press(4'hA); press(2); press(4'hE);
        wait_state(3, 10, "t6 reach S_WAIT");
        b0 = n_push; b3 = n_st;
        key_valid = 1; key_value = 5;
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        late_cnt++;
        repeat (5) @(negedge clk);
        check("t6 state", 32'(state), 0);
        check("t6 held key no push", 32'(n_push - b0), 0);
        check("t6 no start", 32'(n_st - b3), 0);
        key_valid = 0;
        repeat (2) @(negedge clk);
        press(5);
        check("t6 repress push", 32'(n_push - b0), 1);

        // random traffic
        alu_rand = 1; stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 0;
            end else if (r < 50) begin
                press(4'($urandom_range(0, 9)), $urandom_range(1, 3));
            end else if (r < 62) begin
                press(4'($urandom_range(10, 12)), $urandom_range(1, 3));
            end else if (r < 74) begin
                press(4'hE, $urandom_range(1, 3));
            end else if (r < 80) begin
                press(4'hD, $urandom_range(1, 3));
            end else if (r < 88) begin
                press(4'hF, $urandom_range(1, 3));
            end else begin
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end
        stray_en = 0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-to-arithmetic sequencing controller for the calculator. It consumes the scanned key stream (4-bit key code plus valid level from the keypad scanner). It steers digits into the operand entry shift register, latches operand A, the operator and operand B, and runs a start/done handshake with the arithmetic unit. It sits between the keypad scanner / entry shift register and the arithmetic unit, and presents status to the output unit.

## Interface
- MAX_DIGITS, 3: max accepted digits per operand (1..4); further digits ignored
- TIMEOUT, 255: cycles to wait for alu_done before entering error (1..65535)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  scanner level: high while a key is held, key_value stable
- key_value  in  4  key code: 0-9 digit, A add, B sub, C mul, D clear, E equals, F sign toggle
- alu_done  in  1  one-cycle pulse from arithmetic unit, result ready
- alu_ovf  in  1  overflow flag, sampled only with alu_done
- digit_push  out  1  pulse: shift digit into entry register
- digit  out  4  digit value, valid with digit_push
- entry_clear  out  1  pulse: clear entry shift register
- sign_toggle  out  1  pulse: invert sign of current entry
- latch_a / latch_b  out  1 each  pulse: copy entry register into operand A / B
- latch_result_a  out  1  pulse: copy ALU result into operand A (chaining)
- op  out  2  operator: 00 add, 01 sub, 10 mul
- alu_start  out  1  pulse: start arithmetic unit
- result_valid  out  1  level: result displayable
- error  out  1  level: error state
- state  out  3  current state encoding

## Operation
- Key event = key_valid high this cycle and low in the previous sample (internal key_prev register). Holding a key produces exactly one event.
- States: S_A=0 (enter A), S_B=1 (enter B), S_RUN=2, S_WAIT=3, S_RES=4, S_ERR=5.
- Digit event in S_A/S_B: if count<MAX_DIGITS, assert digit_push with digit=key_value and increment count; otherwise ignore.
- F in S_A/S_B: sign_toggle. Ignored elsewhere.
- S_A operator (A/B/C): latch_a, entry_clear, op<=code, count<=0, go to S_B. Zero digits entered is legal (A=0). E ignored.
- S_B operator: if count==0, op is replaced with no other output; if count>0, ignored.
- S_B E: if count==0, go to S_ERR. Otherwise latch_b and go to S_RUN.
- S_RUN: alu_start for exactly one cycle, clear the timeout counter, go to S_WAIT.
- S_WAIT: all keys except D ignored.
  - alu_done with alu_ovf=0: go to S_RES.
  - alu_done with alu_ovf=1: go to S_ERR.
  - Counter reaches TIMEOUT with no alu_done: go to S_ERR.
- S_RES: result_valid=1.
  - Operator: latch_result_a, entry_clear, op<=code, count<=0, go to S_B.
  - Digits, E and F: ignored.
- S_ERR: error=1; only D is accepted.
- D in any state: entry_clear, count<=0, op<=00, clear result_valid and error, go to S_A.
- alu_done outside S_WAIT: ignored.

## Timing
- All outputs are registered. A key sampled at edge N (edge detected) drives its pulses high for the single cycle after edge N; the state changes at the same edge.
- Pulses are one cycle wide. No two of digit_push, entry_clear, latch_a, latch_b and latch_result_a are ever high together, except entry_clear with latch_a or latch_result_a.
- alu_start is high in the cycle after S_RUN is entered. alu_done is accepted earliest one cycle after alu_start.
- result_valid rises the cycle after the alu_done edge.
- Timeout: error rises TIMEOUT+1 cycles after alu_start if no alu_done arrives.
- Simultaneous D key event and alu_done in S_WAIT: D wins, go to S_A with result_valid=0.
- Reset values: state=S_A, count=0, op=00, all pulses 0, result_valid=0, error=0, timeout counter 0.
- key_prev resets to 1, so a key held through reset is not accepted until it is released.
- Reset during S_WAIT: alu_start stays 0, and a later alu_done is ignored.

## Test plan
- Keys 1,2,A,3,E; alu_done 2 cycles after alu_start, alu_ovf=0.
  - Required: digit_push ×3 with digits 1,2,3; latch_a, then op=00; latch_b; one alu_start; result_valid=1, state=4.
- Keys 5,5,5,5 with MAX_DIGITS=3.
  - Required: exactly 3 digit_push pulses, 4th digit ignored; key held 10 cycles yields one event.
- Keys 9,B,E: error=1, state=5, no alu_start. Then key D: entry_clear pulse, state=0, error=0.
- Keys 4,C,2,E with no alu_done and TIMEOUT=8: error rises 9 cycles after alu_start. A late alu_done is ignored.
- From S_RES, key A: latch_result_a together with entry_clear, state=1, op=00. Then keys 7,E: a second alu_start.
- Reset asserted in S_WAIT with a key held:
  - All outputs return to reset values.
  - The held key produces no event until released and re-pressed.
  - alu_done in the next cycle produces no state change.
